// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_pkg : shared constants, dispatch-state type and one-hot decode   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package irq_pkg;

  localparam int NUM_SRC = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } disp_state_e;

  function automatic logic [NUM_SRC-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_SRC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ack_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_ack_timer : saturating ack-wait counter with expiry flag         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irq_ack_timer #(
  parameter int ACK_TIMEOUT = 200,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] C_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [TO_W-1:0] count_q;

  // Saturates at the last count so the expiry flag can never be skipped by a wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != C_LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/irq_dispatch_handshake.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_dispatch_handshake : one-at-a-time IRQ delivery, ack/EOI         |
// | handshake, upstream clear pulse and ack timeout retry                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module irq_dispatch_handshake #(
  parameter int NUM_SRC     = irq_pkg::NUM_SRC,
  parameter int IDX_W       = irq_pkg::IDX_W,
  parameter int ACK_TIMEOUT = 200,
  parameter int TO_W        = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enc_valid,
  input  logic [IDX_W-1:0]   enc_index,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  output logic               cpu_irq,
  output logic [IDX_W-1:0]   cpu_vector,
  output logic [NUM_SRC-1:0] clear_onehot,
  output logic [NUM_SRC-1:0] in_service,
  output logic               busy,
  output logic               timeout_err
);

  import irq_pkg::*;

  disp_state_e        state_q;
  logic               cpu_irq_q;
  logic [IDX_W-1:0]   cpu_vector_q;
  logic [NUM_SRC-1:0] clear_onehot_q;
  logic [NUM_SRC-1:0] in_service_q;
  logic               busy_q;
  logic               timeout_err_q;

  logic               w_timer_clr;
  logic               w_timer_en;
  logic               w_timer_expired;

  // The counter only runs while a vector is waiting for ack; any other state holds it at zero.
  assign w_timer_clr = (state_q != ST_ASSERT);
  assign w_timer_en  = (state_q == ST_ASSERT);

  irq_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .TO_W        (TO_W)
  ) u_ack_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (w_timer_clr),
    .en_i      (w_timer_en),
    .expired_o (w_timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cpu_irq_q      <= 1'b0;
      cpu_vector_q   <= '0;
      clear_onehot_q <= '0;
      in_service_q   <= '0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      clear_onehot_q <= '0;
      timeout_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enc_valid) begin
            cpu_vector_q <= enc_index;
            cpu_irq_q    <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          // Ack takes priority over expiry, so an ack on the last count still wins.
          if (cpu_ack) begin
            cpu_irq_q      <= 1'b0;
            clear_onehot_q <= idx_to_onehot(cpu_vector_q);
            in_service_q   <= idx_to_onehot(cpu_vector_q);
            state_q        <= ST_SERVICE;
          end else if (w_timer_expired) begin
            cpu_irq_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (cpu_eoi) begin
            in_service_q <= '0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          cpu_irq_q    <= 1'b0;
          in_service_q <= '0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_irq      = cpu_irq_q;
  assign cpu_vector   = cpu_vector_q;
  assign clear_onehot = clear_onehot_q;
  assign in_service   = in_service_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_dispatch_handshake.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irq_dispatch_handshake : directed self-checking bench             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_irq_dispatch_handshake;

  logic        clk;
  logic        reset_n;
  logic        enc_valid;
  logic [3:0]  enc_index;
  logic        cpu_ack;
  logic        cpu_eoi;
  logic        cpu_irq;
  logic [3:0]  cpu_vector;
  logic [15:0] clear_onehot;
  logic [15:0] in_service;
  logic        busy;
  logic        timeout_err;

  int total;
  int bad;

  irq_dispatch_handshake dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enc_valid    (enc_valid),
    .enc_index    (enc_index),
    .cpu_ack      (cpu_ack),
    .cpu_eoi      (cpu_eoi),
    .cpu_irq      (cpu_irq),
    .cpu_vector   (cpu_vector),
    .clear_onehot (clear_onehot),
    .in_service   (in_service),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; returns 1 time unit later so outputs are settled and inputs can change.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    enc_valid = 1'b1;
    enc_index = 4'd6;
    cpu_ack   = 1'b1;
    cpu_eoi   = 1'b0;
    step(2);
    total++;
    if ({cpu_irq, busy, timeout_err, cpu_vector, clear_onehot, in_service} !== 39'd0) begin
      bad++;
      $display("FAIL reset_state got irq=%b busy=%b to=%b vec=%0d clr=%h ins=%h want all zero",
               cpu_irq, busy, timeout_err, cpu_vector, clear_onehot, in_service);
    end
    enc_valid = 1'b0;
    cpu_ack   = 1'b0;
    reset_n   = 1'b1;
    step(1);
    total++;
    if (busy !== 1'b0 || cpu_irq !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_release got busy=%b irq=%b want 0 0", busy, cpu_irq);
    end
  endtask

  task automatic test_basic();
    enc_valid = 1'b1;
    enc_index = 4'd9;
    step(1);
    enc_valid = 1'b0;
    total++;
    if (cpu_irq !== 1'b1 || cpu_vector !== 4'd9 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_assert got irq=%b vec=%0d busy=%b want 1 9 1", cpu_irq, cpu_vector, busy);
    end
    step(2);
    cpu_ack = 1'b1;
    step(1);
    cpu_ack = 1'b0;
    total++;
    if (clear_onehot !== 16'h0200 || in_service !== 16'h0200 || cpu_irq !== 1'b0) begin
      bad++;
      $display("FAIL basic_ack got clr=%h ins=%h irq=%b want 0200 0200 0", clear_onehot, in_service, cpu_irq);
    end
    step(1);
    total++;
    if (clear_onehot !== 16'h0000 || in_service !== 16'h0200 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_clear_one_cycle got clr=%h ins=%h busy=%b want 0000 0200 1",
               clear_onehot, in_service, busy);
    end
    cpu_eoi = 1'b1;
    step(1);
    cpu_eoi = 1'b0;
    total++;
    if (in_service !== 16'h0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_eoi got ins=%h busy=%b want 0000 0", in_service, busy);
    end
  endtask

  task automatic test_frozen_vector();
    enc_valid = 1'b1;
    enc_index = 4'd9;
    step(1);
    enc_index = 4'd2;
    step(3);
    total++;
    if (cpu_vector !== 4'd9 || cpu_irq !== 1'b1) begin
      bad++;
      $display("FAIL frozen_vec got vec=%0d irq=%b want 9 1", cpu_vector, cpu_irq);
    end
    cpu_ack = 1'b1;
    step(1);
    cpu_ack = 1'b0;
    total++;
    if (cpu_vector !== 4'd9 || in_service !== 16'h0200) begin
      bad++;
      $display("FAIL frozen_service got vec=%0d ins=%h want 9 0200", cpu_vector, in_service);
    end
    cpu_eoi = 1'b1;
    step(1);
    cpu_eoi = 1'b0;
    total++;
    if (busy !== 1'b0 || cpu_irq !== 1'b0) begin
      bad++;
      $display("FAIL idle_gap got busy=%b irq=%b want 0 0", busy, cpu_irq);
    end
    step(1);
    total++;
    if (cpu_irq !== 1'b1 || cpu_vector !== 4'd2) begin
      bad++;
      $display("FAIL next_delivery got irq=%b vec=%0d want 1 2", cpu_irq, cpu_vector);
    end
    enc_valid = 1'b0;
    cpu_ack   = 1'b1;
    step(1);
    cpu_ack = 1'b0;
    cpu_eoi = 1'b1;
    step(1);
    cpu_eoi = 1'b0;
  endtask

  task automatic test_timeout();
    int irq_cycles;
    enc_valid = 1'b1;
    enc_index = 4'd5;
    step(1);
    irq_cycles = 0;
    for (int i = 0; i < 199; i++) begin
      if (cpu_irq === 1'b1 && timeout_err === 1'b0) irq_cycles++;
      step(1);
    end
    if (cpu_irq === 1'b1 && timeout_err === 1'b0) irq_cycles++;
    total++;
    if (irq_cycles !== 200) begin
      bad++;
      $display("FAIL timeout_irq_width got %0d cycles want 200", irq_cycles);
    end
    step(1);
    total++;
    if (cpu_irq !== 1'b0 || timeout_err !== 1'b1 || clear_onehot !== 16'h0000 ||
        busy !== 1'b0 || in_service !== 16'h0000) begin
      bad++;
      $display("FAIL timeout_fire got irq=%b to=%b clr=%h busy=%b ins=%h want 0 1 0000 0 0000",
               cpu_irq, timeout_err, clear_onehot, busy, in_service);
    end
    step(1);
    total++;
    if (cpu_irq !== 1'b1 || cpu_vector !== 4'd5 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_retry got irq=%b vec=%0d to=%b want 1 5 0", cpu_irq, cpu_vector, timeout_err);
    end
    enc_valid = 1'b0;
    cpu_ack   = 1'b1;
    step(1);
    cpu_ack = 1'b0;
    cpu_eoi = 1'b1;
    step(1);
    cpu_eoi = 1'b0;
  endtask

  task automatic test_ack_on_timeout();
    enc_valid = 1'b1;
    enc_index = 4'd7;
    step(1);
    enc_valid = 1'b0;
    step(199);
    cpu_ack = 1'b1;
    step(1);
    cpu_ack = 1'b0;
    total++;
    if (clear_onehot !== 16'h0080 || in_service !== 16'h0080 || timeout_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ack_at_timeout got clr=%h ins=%h to=%b busy=%b want 0080 0080 0 1",
               clear_onehot, in_service, timeout_err, busy);
    end
    cpu_eoi = 1'b1;
    step(1);
    cpu_eoi = 1'b0;
  endtask

  task automatic test_misuse();
    cpu_eoi = 1'b1;
    step(1);
    total++;
    if (busy !== 1'b0 || cpu_irq !== 1'b0) begin
      bad++;
      $display("FAIL eoi_in_idle got busy=%b irq=%b want 0 0", busy, cpu_irq);
    end
    enc_valid = 1'b1;
    enc_index = 4'd3;
    step(1);
    enc_valid = 1'b0;
    step(1);
    total++;
    if (cpu_irq !== 1'b1 || busy !== 1'b1 || in_service !== 16'h0000) begin
      bad++;
      $display("FAIL eoi_in_assert got irq=%b busy=%b ins=%h want 1 1 0000", cpu_irq, busy, in_service);
    end
    cpu_ack = 1'b1;
    step(1);
    cpu_eoi = 1'b0;
    total++;
    if (clear_onehot !== 16'h0008 || in_service !== 16'h0008 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ack_with_eoi got clr=%h ins=%h busy=%b want 0008 0008 1", clear_onehot, in_service, busy);
    end
    step(1);
    cpu_ack = 1'b0;
    total++;
    if (clear_onehot !== 16'h0000 || in_service !== 16'h0008 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ack_in_service got clr=%h ins=%h busy=%b want 0000 0008 1", clear_onehot, in_service, busy);
    end
    cpu_eoi = 1'b1;
    step(1);
    cpu_eoi = 1'b0;
  endtask

  task automatic test_reset_mid_service();
    enc_valid = 1'b1;
    enc_index = 4'd15;
    step(1);
    enc_valid = 1'b0;
    cpu_ack   = 1'b1;
    step(1);
    cpu_ack = 1'b0;
    step(1);
    total++;
    if (in_service !== 16'h8000) begin
      bad++;
      $display("FAIL pre_reset_service got ins=%h want 8000", in_service);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (in_service !== 16'h0000 || cpu_irq !== 1'b0 || busy !== 1'b0 || clear_onehot !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset got ins=%h irq=%b busy=%b clr=%h want 0000 0 0 0000",
               in_service, cpu_irq, busy, clear_onehot);
    end
    step(1);
    reset_n   = 1'b1;
    enc_valid = 1'b1;
    enc_index = 4'd1;
    step(1);
    enc_valid = 1'b0;
    total++;
    if (cpu_irq !== 1'b1 || cpu_vector !== 4'd1 || clear_onehot !== 16'h0000) begin
      bad++;
      $display("FAIL after_reset_delivery got irq=%b vec=%0d clr=%h want 1 1 0000", cpu_irq, cpu_vector, clear_onehot);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_frozen_vector();
    test_timeout();
    test_ack_on_timeout();
    test_misuse();
    test_reset_mid_service();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
